nyq_ctrl: RTL
=============

NYQ_CTRL -- requirements
Module: nyq_ctrl

Interface
REQ-001 Parameter DECIM, default 8, decimation ratio and number of coefficient phases per output; power of two, 2..16.
REQ-002 Parameter PH_WIDTH, default 3, phase index width; SHALL equal log2(DECIM).
REQ-003 Parameter CNT_WIDTH, default 16, frame counter width.
REQ-004 Clk_CI  in  1  single clock; all state updates on its rising edge.
REQ-005 Rst_RI  in  1  synchronous, active-high reset.
REQ-006 WrEn_SI  in  1  external coefficient-write in progress; coefficients are unstable while high.
REQ-007 Flush_SI  in  1  abort the current partial frame.
REQ-008 InValid_SI  in  1  input sample valid.
REQ-009 InReady_SO  out  1  input sample accepted when InValid_SI && InReady_SO.
REQ-010 Phase_DO  out  PH_WIDTH  coefficient phase used by the MAC lanes for the sample accepted this cycle.
REQ-011 MacEn_SO  out  1  MAC lanes accumulate this cycle.
REQ-012 MacClr_SO  out  1  MAC lanes clear this cycle.
REQ-013 ChainEn_SO  out  1  lane partial-sum chain registers capture this cycle.
REQ-014 OutValid_SO  out  1  filtered output available.
REQ-015 OutReady_SI  in  1  downstream accepts output when OutValid_SO && OutReady_SI.
REQ-016 FrameCnt_DO  out  CNT_WIDTH  count of completed output handshakes.
REQ-017 DropCnt_DO  out  8  count of discarded partial frames.

Function
REQ-018 States SHALL be IDLE, ACCUM, DUMP and CFG, encoded internally.
REQ-019 IDLE: phase 0; InReady_SO=1 unless WrEn_SI=1 or the output-stall condition of REQ-024 holds; an accepted sample SHALL assert MacEn_SO combinationally, increment the phase, and move to ACCUM.
REQ-020 ACCUM: each accepted sample SHALL assert MacEn_SO with Phase_DO = current phase, then increment the phase; cycles with no sample SHALL hold the phase and keep MacEn_SO=0.
REQ-021 A sample accepted at phase DECIM-1 SHALL wrap the phase to 0 and move to DUMP.
REQ-022 DUMP lasts exactly one cycle with ChainEn_SO=1, MacClr_SO=1 and InReady_SO=0; the next state is IDLE and OutValid_SO SHALL be 1 from the following cycle.
REQ-023 Latency: last sample accepted in cycle N -> ChainEn_SO in N+1 -> OutValid_SO first high in N+2.
REQ-024 OutValid_SO SHALL hold until an output handshake. Accumulation of the next frame may proceed meanwhile, but InReady_SO SHALL be 0 at phase DECIM-1 while OutValid_SO=1 and OutReady_SI=0, so no output is overwritten.
REQ-025 A DUMP coinciding with an output handshake SHALL keep OutValid_SO=1 for the new frame.
REQ-026 FrameCnt_DO SHALL increment on each output handshake and wrap modulo 2^CNT_WIDTH.
REQ-027 WrEn_SI=1 in any state except DUMP SHALL move the block to CFG: InReady_SO=0, MacEn_SO=0, MacClr_SO=1 and phase=0.
REQ-028 CFG SHALL be held while WrEn_SI=1 and SHALL return to IDLE in the first cycle WrEn_SI=0.
REQ-029 WrEn_SI=1 during DUMP SHALL let DUMP complete and enter CFG in the next cycle.
REQ-030 Flush_SI=1 SHALL behave as one CFG-entry cycle (MacClr_SO=1, phase 0, input blocked) and then return to IDLE; WrEn_SI has priority over Flush_SI.
REQ-031 A flush or WrEn entry with phase != 0 SHALL increment DropCnt_DO, saturating at 255.
REQ-032 A pending OutValid_SO SHALL be preserved across CFG and flush.
REQ-033 MacEn_SO and MacClr_SO SHALL never both be 1 in the same cycle.

Reset
REQ-034 With Rst_RI=1 at a clock edge, the block SHALL enter IDLE with: phase 0, InReady_SO=0 during reset, MacEn_SO=0, MacClr_SO=1, ChainEn_SO=0, OutValid_SO=0, FrameCnt_DO=0, DropCnt_DO=0.
REQ-035 Reset mid-frame or with an output pending SHALL discard both, without incrementing DropCnt_DO.
REQ-036 InReady_SO SHALL be 1 in the first cycle after Rst_RI falls, given WrEn_SI=0.

Verification
REQ-037 Continuous input, DECIM=8, OutReady_SI=1 -> Phase_DO 0..7; ChainEn_SO one cycle after phase 7; OutValid_SO at N+2; FrameCnt_DO=1 after the handshake.
REQ-038 OutReady_SI=0 for 20 cycles with continuous input -> second frame stalls at phase 7 (InReady_SO=0); no output lost; both outputs delivered in order.
REQ-039 WrEn_SI for 3 cycles at phase 4 -> MacClr_SO=1, CFG for 3 cycles, DropCnt_DO=1, next sample at phase 0.
REQ-040 Flush_SI at phase 0 -> DropCnt_DO unchanged; Flush_SI and WrEn_SI together -> CFG path taken.
REQ-041 Rst_RI asserted mid-frame with OutValid_SO=1 -> all outputs at REQ-034 values on the next edge; FrameCnt_DO=0.
REQ-042 Run 65536 frames -> FrameCnt_DO wraps to 0; 300 aborts -> DropCnt_DO saturates at 255.

Source files
------------

// File: rtl/nyq_ctrl_if.sv
// Handshake and control bundle between the decimator controller and its MAC datapath / neighbours.
// The slave modport is the controller's view of the bundle.
interface nyq_ctrl_if #(
  parameter int PH_WIDTH  = 3,
  parameter int CNT_WIDTH = 16
);
  logic                 WrEn_SI;
  logic                 Flush_SI;
  logic                 InValid_SI;
  logic                 InReady_SO;
  logic [PH_WIDTH-1:0]  Phase_DO;
  logic                 MacEn_SO;
  logic                 MacClr_SO;
  logic                 ChainEn_SO;
  logic                 OutValid_SO;
  logic                 OutReady_SI;
  logic [CNT_WIDTH-1:0] FrameCnt_DO;
  logic [7:0]           DropCnt_DO;

  modport slave (
    input  WrEn_SI, Flush_SI, InValid_SI, OutReady_SI,
    output InReady_SO, Phase_DO, MacEn_SO, MacClr_SO, ChainEn_SO,
           OutValid_SO, FrameCnt_DO, DropCnt_DO
  );

  modport master (
    output WrEn_SI, Flush_SI, InValid_SI, OutReady_SI,
    input  InReady_SO, Phase_DO, MacEn_SO, MacClr_SO, ChainEn_SO,
           OutValid_SO, FrameCnt_DO, DropCnt_DO
  );
endinterface

// File: rtl/nyq_ctrl.sv
// Polyphase decimator control: sequences coefficient phases per input sample, dumps the
// lane chain once per DECIM samples and holds the result until the consumer takes it.
module nyq_ctrl #(
  parameter int DECIM     = 8,
  parameter int PH_WIDTH  = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic       Clk_CI,
  input  logic       Rst_RI,
  nyq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DUMP, CFG} state_t;

  localparam logic [PH_WIDTH-1:0] PH_LAST = PH_WIDTH'(DECIM - 1);

  state_t               state, state_nxt;
  logic [PH_WIDTH-1:0]  phase, phase_nxt;
  logic                 out_valid, out_valid_nxt;
  logic [CNT_WIDTH-1:0] frame_cnt;
  logic [7:0]           drop_cnt;

  logic ready, accept, mac_en, mac_clr, chain_en, dump, drop, out_hs, stall;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    ready     = 1'b0;
    accept    = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    chain_en  = 1'b0;
    dump      = 1'b0;
    drop      = 1'b0;
    out_hs    = out_valid && bus.OutReady_SI;
    // Holding back the last sample of a frame keeps a pending, unaccepted output intact.
    stall     = (phase == PH_LAST) && out_valid && !bus.OutReady_SI;

    case (state)
      IDLE, ACCUM: begin
        if (bus.WrEn_SI || bus.Flush_SI) begin
          mac_clr   = 1'b1;
          phase_nxt = '0;
          drop      = (phase != '0);
          state_nxt = bus.WrEn_SI ? CFG : IDLE;
        end else begin
          ready  = !stall;
          accept = bus.InValid_SI && ready;
          mac_en = accept;
          if (accept) begin
            if (phase == PH_LAST) begin
              phase_nxt = '0;
              state_nxt = DUMP;
            end else begin
              phase_nxt = phase + 1'b1;
              state_nxt = ACCUM;
            end
          end
        end
      end
      DUMP: begin
        chain_en  = 1'b1;
        mac_clr   = 1'b1;
        dump      = 1'b1;
        state_nxt = bus.WrEn_SI ? CFG : IDLE;
      end
      CFG: begin
        mac_clr   = 1'b1;
        phase_nxt = '0;
        if (!bus.WrEn_SI) state_nxt = IDLE;
      end
      default: begin
        mac_clr   = 1'b1;
        phase_nxt = '0;
        state_nxt = IDLE;
      end
    endcase

    out_valid_nxt = dump ? 1'b1 : (out_hs ? 1'b0 : out_valid);

    if (Rst_RI) begin
      ready    = 1'b0;
      mac_en   = 1'b0;
      mac_clr  = 1'b1;
      chain_en = 1'b0;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state     <= IDLE;
      phase     <= '0;
      out_valid <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      out_valid <= out_valid_nxt;
      frame_cnt <= frame_cnt + CNT_WIDTH'(out_hs);
      drop_cnt  <= drop ? sat_inc8(drop_cnt) : drop_cnt;
    end
  end

  assign bus.InReady_SO  = ready;
  assign bus.Phase_DO    = mac_clr ? '0 : phase;
  assign bus.MacEn_SO    = mac_en;
  assign bus.MacClr_SO   = mac_clr;
  assign bus.ChainEn_SO  = chain_en;
  assign bus.OutValid_SO = out_valid;
  assign bus.FrameCnt_DO = frame_cnt;
  assign bus.DropCnt_DO  = drop_cnt;

endmodule
